quire_to_pd_normalizer: RTL and testbench
=========================================

// Module: quire_to_pd_normalizer
// PURPOSE
//  Converts a two's-complement fixed-point quire (exact accumulator) into the pd
//  (denormalized posit) form: sign, zero, NaR, scale, fraction, guard/round/sticky.
//  Sits directly upstream of posit_normalize_I and drives its pd.slave port.
//  Leading-one search is multi-cycle, CHUNK_WIDTH bits per cycle, behind a
//  valid/ready handshake.
// PARAMETERS
//  POSIT_WIDTH      32      target posit width
//  POSIT_ES         2       target exponent size
//  PD_TYPE          NORMAL  pd flavour; sets scale_width/fraction_width via package functions
//  QUIRE_WIDTH      512     quire width in bits; must be a multiple of CHUNK_WIDTH
//  QUIRE_FRAC_WIDTH 240     quire bits right of the binary point (bit 240 = 1.0)
//  CHUNK_WIDTH      32      bits scanned per cycle; N_CHUNKS = QUIRE_WIDTH/CHUNK_WIDTH
// PORTS
//  clk           in   1            clock, all state on rising edge
//  rst           in   1            asynchronous, active-high reset
//  quire_i       in   QUIRE_WIDTH  two's-complement quire
//  in_valid_i    in   1            quire_i is valid
//  in_ready_o    out  1            block accepts quire_i
//  denormalized  pd.master  -      sign, zero, NaR, scale[scale_width], fraction[fraction_width], guard, round, sticky
//  out_valid_o   out  1            pd fields valid
//  out_ready_i   in   1            consumer takes pd fields
// BEHAVIOUR
//  Reset: state=IDLE; out_valid_o=0; all pd fields 0; in_ready_o=0 while rst is high, then 1.
//  FSM: IDLE -(in_valid&in_ready)-> ABS -> SCAN (exactly N_CHUNKS cycles) -> PACK -> HOLD -(out_ready)-> IDLE.
//  IDLE: in_ready_o=1. On accept, register quire_i. in_ready_o=0 in every other state.
//  ABS: sign=q[MSB]. NaR=(q==1<<(QUIRE_WIDTH-1)). zero=(q==0). mag=sign?-q:q (unsigned).
//  SCAN: chunk counter goes from MSB chunk down. The first nonzero chunk index is latched.
//   Scan always runs all N_CHUNKS cycles, so latency is fixed.
//  PACK: lz = leading zeros of mag, from the latched chunk and posit_lzc on it.
//   scale = (QUIRE_WIDTH-1-QUIRE_FRAC_WIDTH) - lz. mag<<lz drops the hidden one.
//   fraction = next fraction_width bits; guard and round = next 2 bits; sticky = OR of all remaining bits.
//  Clamp: scale > (POSIT_WIDTH-2)<<ES -> scale=max, fraction=0, GRS=000.
//   scale < -((POSIT_WIDTH-2)<<ES) -> scale=min, fraction=0, GRS=000 (posits never round to 0).
//  zero or NaR: scale, fraction and GRS are forced to 0.
//  HOLD: out_valid_o=1. All pd fields stay stable until out_ready_i. A handshake returns to IDLE.
//  Latency: accept edge to out_valid_o = N_CHUNKS+2 cycles (18 at defaults).
//   Minimum initiation interval is N_CHUNKS+3.
//  rst mid-operation: immediate return to IDLE, out_valid_o=0, in-flight quire discarded.
//  Widths: scale is signed scale_width; the subtraction is done at clog2(QUIRE_WIDTH)+2 bits before clamping.
// STRUCTURE
//  posit_defines package gains get_quire_width(POSIT_WIDTH) and
//   get_quire_frac_width(POSIT_WIDTH,POSIT_ES), used as parameter defaults.
//  The FSM state enum is local to the module.
//  Sub-module: posit_lzc #(WIDTH) is a combinational leading-zero counter
//   with an all-zero flag, reused per chunk.
//  The PACK barrel shift reuses sticky_shifter semantics in the left direction, or is inline.
// TESTING
//  (defaults; 1.0 = 1<<240; fraction_width from package, 27 for posit32/es2)
//  1) quire=1<<240, out_ready=1 -> sign0 zero0 NaR0 scale=0 fraction=0 GRS=000;
//     out_valid exactly 18 cycles after accept.
//  2) quire=-(3<<240) -> sign1 scale=1 fraction=1<<26 (1.5) GRS=000.
//  3) quire=0 -> zero=1, rest 0. quire=1<<511 -> NaR=1, zero=0, scale=0.
//  4) quire=(1<<240)|1 -> scale=0 fraction=0 guard0 round0 sticky1.
//     quire=1 -> scale=-120 (clamped) fraction=0 GRS=000.
//  5) out_ready held low 5 cycles after out_valid -> fields stable, in_ready=0, no second accept.
//     Release -> IDLE next cycle.
//  6) Assert rst during SCAN cycle 7 -> out_valid=0, state IDLE.
//     Next input quire=1<<241 -> scale=1 after 18 cycles.

Source files
------------

// File: rtl/quire_to_pd_normalizer_pkg.sv
// Shared types and width helpers for the quire-to-pd conversion path.
package quire_to_pd_normalizer_pkg;

   // pd flavours: wide keeps the exponent bits in the fraction field
   typedef enum logic [0:0] {PdNormal, PdWide} pd_type_e;

   function automatic int unsigned get_quire_width(int unsigned posit_width);
      return 16 * posit_width;
   endfunction

   function automatic int unsigned get_quire_frac_width(int unsigned posit_width,
                                                        int unsigned posit_es);
      return (posit_width - 2) << (posit_es + 1);
   endfunction

   // Largest representable |scale|: maxpos = useed^(N-2)
   function automatic int unsigned get_max_scale(int unsigned posit_width,
                                                 int unsigned posit_es);
      return (posit_width - 2) << posit_es;
   endfunction

   function automatic int unsigned get_scale_width(int unsigned posit_width,
                                                   int unsigned posit_es);
      return $clog2(get_max_scale(posit_width, posit_es) + 1) + 1;
   endfunction

   function automatic int unsigned get_fraction_width(int unsigned posit_width,
                                                      int unsigned posit_es,
                                                      pd_type_e pd_type);
      return (pd_type == PdWide) ? posit_width - 3 : posit_width - 3 - posit_es;
   endfunction

endpackage

// File: rtl/quire_to_pd_normalizer_lzc.sv
// Combinational leading-zero counter with an all-zero flag.
module quire_to_pd_normalizer_lzc #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     data_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 zero_o
);

   // Highest set bit wins because it is visited last
   always_comb begin
      cnt_o  = '0;
      zero_o = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) begin
            cnt_o  = CNT_WIDTH'(WIDTH - 1 - i);
            zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/quire_to_pd_normalizer.sv
// Converts a two's-complement quire into pd fields with a fixed-latency chunked LZ scan.
module quire_to_pd_normalizer
   import quire_to_pd_normalizer_pkg::*;
#(
   parameter int unsigned POSIT_WIDTH      = 32,
   parameter int unsigned POSIT_ES         = 2,
   parameter pd_type_e    PD_TYPE          = PdNormal,
   parameter int unsigned QUIRE_WIDTH      = get_quire_width(POSIT_WIDTH),
   parameter int unsigned QUIRE_FRAC_WIDTH = get_quire_frac_width(POSIT_WIDTH, POSIT_ES),
   parameter int unsigned CHUNK_WIDTH      = 32,
   localparam int unsigned SCALE_WIDTH     = get_scale_width(POSIT_WIDTH, POSIT_ES),
   localparam int unsigned FRACTION_WIDTH  = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [QUIRE_WIDTH-1:0]    quire_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic                      pd_sign_o,
   output logic                      pd_zero_o,
   output logic                      pd_nar_o,
   output logic [SCALE_WIDTH-1:0]    pd_scale_o,
   output logic [FRACTION_WIDTH-1:0] pd_fraction_o,
   output logic                      pd_guard_o,
   output logic                      pd_round_o,
   output logic                      pd_sticky_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i
);

   localparam int unsigned N_CHUNKS  = QUIRE_WIDTH / CHUNK_WIDTH;
   localparam int unsigned IDX_WIDTH = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam int unsigned CNT_WIDTH = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;
   localparam int unsigned LZ_WIDTH  = $clog2(QUIRE_WIDTH);
   localparam int unsigned SUB_WIDTH = LZ_WIDTH + 2;
   // Scale of the quire MSB position
   localparam int SCALE_BIAS = int'(QUIRE_WIDTH) - 1 - int'(QUIRE_FRAC_WIDTH);
   localparam int SCALE_MAX  = int'(get_max_scale(POSIT_WIDTH, POSIT_ES));
   localparam logic [QUIRE_WIDTH-1:0] NAR_PATTERN = {1'b1, {(QUIRE_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StAbs, StScan, StPack, StHold} state_e;

   state_e                    state_q, state_d;
   logic [IDX_WIDTH-1:0]      cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]      idx_q;
   logic                      found_q;
   logic [QUIRE_WIDTH-1:0]    q_q, mag_q;
   logic                      sign_q, zero_q, nar_q;
   logic                      accept;

   logic [CHUNK_WIDTH-1:0]    chunk_arr [N_CHUNKS];
   logic [IDX_WIDTH-1:0]      chunk_sel;
   logic [CNT_WIDTH-1:0]      lzc_cnt;
   logic                      lzc_zero;

   logic [LZ_WIDTH-1:0]       lz;
   logic [QUIRE_WIDTH-2:0]    shifted;
   logic signed [SUB_WIDTH-1:0] scale_full;
   int                        scale_int;
   logic [SCALE_WIDTH-1:0]    pack_scale;
   logic [FRACTION_WIDTH-1:0] pack_fraction;
   logic                      pack_guard, pack_round, pack_sticky;

   logic                      pd_sign_q, pd_zero_q, pd_nar_q;
   logic [SCALE_WIDTH-1:0]    pd_scale_q;
   logic [FRACTION_WIDTH-1:0] pd_fraction_q;
   logic                      pd_guard_q, pd_round_q, pd_sticky_q;

   assign in_ready_o  = (state_q == StIdle) && !rst;
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = (state_q == StHold);

   for (genvar g = 0; g < N_CHUNKS; g++) begin : g_chunk
      assign chunk_arr[g] = mag_q[g*CHUNK_WIDTH +: CHUNK_WIDTH];
   end

   // One LZC serves both the scan (current chunk) and the pack (latched chunk)
   assign chunk_sel = (state_q == StPack) ? idx_q : cnt_q;

   quire_to_pd_normalizer_lzc #(
      .WIDTH (CHUNK_WIDTH)
   ) u_lzc (
      .data_i (chunk_arr[chunk_sel]),
      .cnt_o  (lzc_cnt),
      .zero_o (lzc_zero)
   );

   // FSM state and scan counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; scan always walks every chunk so latency is fixed
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StAbs;
         StAbs: begin
            state_d = StScan;
            cnt_d   = IDX_WIDTH'(N_CHUNKS - 1);
         end
         StScan: begin
            if (cnt_q == '0) state_d = StPack;
            else             cnt_d   = cnt_q - IDX_WIDTH'(1);
         end
         StPack: state_d = StHold;
         StHold: if (out_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Normalisation of the magnitude, scale computation and saturation
   always_comb begin
      lz         = LZ_WIDTH'((N_CHUNKS - 1 - 32'(idx_q)) * CHUNK_WIDTH + 32'(lzc_cnt));
      shifted    = (QUIRE_WIDTH-1)'(mag_q << lz);
      scale_full = SUB_WIDTH'(SCALE_BIAS) - SUB_WIDTH'(lz);
      scale_int  = int'(scale_full);

      pack_scale    = SCALE_WIDTH'(scale_int);
      pack_fraction = shifted[QUIRE_WIDTH-2 -: FRACTION_WIDTH];
      pack_guard    = shifted[QUIRE_WIDTH-2-FRACTION_WIDTH];
      pack_round    = shifted[QUIRE_WIDTH-3-FRACTION_WIDTH];
      pack_sticky   = |shifted[QUIRE_WIDTH-4-FRACTION_WIDTH:0];

      if (zero_q || nar_q || scale_int > SCALE_MAX || scale_int < -SCALE_MAX) begin
         pack_fraction = '0;
         pack_guard    = 1'b0;
         pack_round    = 1'b0;
         pack_sticky   = 1'b0;
      end
      // Saturate rather than round to zero or infinity
      if (zero_q || nar_q)            pack_scale = '0;
      else if (scale_int > SCALE_MAX)  pack_scale = SCALE_WIDTH'(SCALE_MAX);
      else if (scale_int < -SCALE_MAX) pack_scale = SCALE_WIDTH'(-SCALE_MAX);
   end

   // Datapath registers, updated according to the current FSM phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q           <= '0;
         mag_q         <= '0;
         sign_q        <= 1'b0;
         zero_q        <= 1'b0;
         nar_q         <= 1'b0;
         found_q       <= 1'b0;
         idx_q         <= '0;
         pd_sign_q     <= 1'b0;
         pd_zero_q     <= 1'b0;
         pd_nar_q      <= 1'b0;
         pd_scale_q    <= '0;
         pd_fraction_q <= '0;
         pd_guard_q    <= 1'b0;
         pd_round_q    <= 1'b0;
         pd_sticky_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: if (accept) q_q <= quire_i;
            StAbs: begin
               sign_q  <= q_q[QUIRE_WIDTH-1];
               zero_q  <= (q_q == '0);
               nar_q   <= (q_q == NAR_PATTERN);
               mag_q   <= q_q[QUIRE_WIDTH-1] ? -q_q : q_q;
               found_q <= 1'b0;
               idx_q   <= '0;
            end
            StScan: begin
               if (!found_q && !lzc_zero) begin
                  found_q <= 1'b1;
                  idx_q   <= cnt_q;
               end
            end
            StPack: begin
               pd_sign_q     <= sign_q;
               pd_zero_q     <= zero_q;
               pd_nar_q      <= nar_q;
               pd_scale_q    <= pack_scale;
               pd_fraction_q <= pack_fraction;
               pd_guard_q    <= pack_guard;
               pd_round_q    <= pack_round;
               pd_sticky_q   <= pack_sticky;
            end
            default: ;
         endcase
      end
   end

   assign pd_sign_o     = pd_sign_q;
   assign pd_zero_o     = pd_zero_q;
   assign pd_nar_o      = pd_nar_q;
   assign pd_scale_o    = pd_scale_q;
   assign pd_fraction_o = pd_fraction_q;
   assign pd_guard_o    = pd_guard_q;
   assign pd_round_o    = pd_round_q;
   assign pd_sticky_o   = pd_sticky_q;

endmodule

// File: tb/tb_quire_to_pd_normalizer.sv
// Self-checking bench for quire_to_pd_normalizer at default parameters.
module tb_quire_to_pd_normalizer;
   import quire_to_pd_normalizer_pkg::*;

   localparam int QW   = 512;
   localparam int QFW  = 240;
   localparam int FW   = 27;
   localparam int SW   = 8;
   localparam int SMAX = 120;
   localparam int LAT  = 18;
   localparam logic [QW-1:0] ONE = {{(QW-1){1'b0}}, 1'b1};
   localparam logic [QW-1:0] NAR = {1'b1, {(QW-1){1'b0}}};

   logic          clk = 1'b0;
   logic          rst;
   logic [QW-1:0] quire;
   logic          in_valid, in_ready;
   logic          pd_sign, pd_zero, pd_nar, pd_guard, pd_round, pd_sticky;
   logic [SW-1:0] pd_scale;
   logic [FW-1:0] pd_fraction;
   logic          out_valid, out_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string         name;
      logic [QW-1:0] q;
      logic [40:0]   exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   quire_to_pd_normalizer dut (
      .clk           (clk),
      .rst           (rst),
      .quire_i       (quire),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .pd_sign_o     (pd_sign),
      .pd_zero_o     (pd_zero),
      .pd_nar_o      (pd_nar),
      .pd_scale_o    (pd_scale),
      .pd_fraction_o (pd_fraction),
      .pd_guard_o    (pd_guard),
      .pd_round_o    (pd_round),
      .pd_sticky_o   (pd_sticky),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready)
   );

   function automatic logic [40:0] mk(input logic sign, input logic zero, input logic nar,
                                      input int scale, input int frac,
                                      input logic g, input logic r, input logic s);
      return {sign, zero, nar, SW'(scale), FW'(frac), g, r, s};
   endfunction

   function automatic logic [40:0] dut_pd();
      return {pd_sign, pd_zero, pd_nar, pd_scale, pd_fraction, pd_guard, pd_round, pd_sticky};
   endfunction

   // Reference: value-level view (locate the top bit, read bits below it)
   function automatic logic [40:0] model(input logic [QW-1:0] q);
      logic          sign;
      logic [QW-1:0] mag;
      int            msb;
      int            scale;
      logic [FW-1:0] frac;
      logic          g, r, s;
      sign = q[QW-1];
      if (q == '0) return mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      if (q == NAR) return mk(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      mag = sign ? -q : q;
      msb = 0;
      for (int i = 0; i < QW; i++) if (mag[i]) msb = i;
      scale = msb - QFW;
      if (scale > SMAX) return mk(sign, 1'b0, 1'b0, SMAX, 0, 1'b0, 1'b0, 1'b0);
      if (scale < -SMAX) return mk(sign, 1'b0, 1'b0, -SMAX, 0, 1'b0, 1'b0, 1'b0);
      frac = '0;
      for (int k = 0; k < FW; k++) if (msb - 1 - k >= 0) frac[FW-1-k] = mag[msb-1-k];
      g = (msb - 1 - FW >= 0) ? mag[msb-1-FW] : 1'b0;
      r = (msb - 2 - FW >= 0) ? mag[msb-2-FW] : 1'b0;
      s = 1'b0;
      for (int i = 0; i < msb - 2 - FW; i++) s = s | mag[i];
      return mk(sign, 1'b0, 1'b0, scale, int'(frac), g, r, s);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [QW-1:0] q, input logic [40:0] exp);
      vec_t v;
      v.name = name;
      v.q    = q;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   // Full handshake: accept, measure latency, capture fields, retire
   task automatic transact(input string name, input logic [QW-1:0] q,
                           output logic [40:0] got, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      quire    = q;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      got       = dut_pd();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [40:0]   got, held;
      logic [QW-1:0] qa;
      int            lat, seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      quire     = '0;

      // Reset state
      #3;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fields", 64'(dut_pd()), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed table
      add("one",       ONE << 240,                    mk(0, 0, 0, 0, 0, 0, 0, 0));
      add("neg_1p5",   -((ONE << 241) | (ONE << 240)), mk(1, 0, 0, 1, 1 << 26, 0, 0, 0));
      add("zero",      '0,                            mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("nar",       NAR,                           mk(1, 0, 1, 0, 0, 0, 0, 0));
      add("sticky",    (ONE << 240) | ONE,            mk(0, 0, 0, 0, 0, 0, 0, 1));
      add("guard",     (ONE << 240) | (ONE << 212),   mk(0, 0, 0, 0, 0, 1, 0, 0));
      add("round",     (ONE << 240) | (ONE << 211),   mk(0, 0, 0, 0, 0, 0, 1, 0));
      add("frac_lsb",  (ONE << 240) | (ONE << 213),   mk(0, 0, 0, 0, 1, 0, 0, 0));
      add("tiny",      ONE,                           mk(0, 0, 0, -120, 0, 0, 0, 0));
      add("neg_tiny",  -ONE,                          mk(1, 0, 0, -120, 0, 0, 0, 0));
      add("max_exact", ONE << 360,                    mk(0, 0, 0, 120, 0, 0, 0, 0));
      add("over",      (ONE << 361) | (ONE << 360) | ONE, mk(0, 0, 0, 120, 0, 0, 0, 0));
      add("near_min",  (ONE << 121) | (ONE << 120) | ONE, mk(0, 0, 0, -119, 1 << 26, 0, 0, 1));
      add("min_exact", (ONE << 120) | (ONE << 119),   mk(0, 0, 0, -120, 1 << 26, 0, 0, 0));
      add("under",     (ONE << 119) | (ONE << 118) | ONE, mk(0, 0, 0, -120, 0, 0, 0, 0));
      add("huge",      ONE << 510,                    mk(0, 0, 0, 120, 0, 0, 0, 0));
      add("neg_huge",  NAR | ONE,                     mk(1, 0, 0, 120, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         transact(vecs[i].name, vecs[i].q, got, lat);
         check({vecs[i].name, "_lat"}, 64'(lat), 64'(LAT));
         check(vecs[i].name, 64'(got), 64'(vecs[i].exp));
      end

      // Backpressure: fields stable, no second accept while held
      qa = (ONE << 252) | (ONE << 250) | (ONE << 100);
      quire    = qa;
      in_valid = 1'b1;
      @(posedge clk); #1;
      quire = ONE << 300;
      lat   = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_lat", 64'(lat), 64'(LAT));
      held = dut_pd();
      check("bp_value", 64'(held), 64'(model(qa)));
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_stable%0d", c), 64'(dut_pd()), 64'(held));
         check($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
         check($sformatf("bp_out_valid%0d", c), 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);

      // Reset during the scan discards the in-flight quire
      quire    = ONE << 300;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_idle", 64'(in_ready), 64'd1);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("midrst_discard", 64'(seen), 64'd0);
      transact("after_rst", ONE << 241, got, lat);
      check("after_rst_lat", 64'(lat), 64'(LAT));
      check("after_rst", 64'(got), 64'(mk(0, 0, 0, 1, 0, 0, 0, 0)));

      // Randomised magnitudes and signs against the reference
      for (int t = 0; t < 40; t++) begin
         logic [QW-1:0] q;
         for (int w = 0; w < QW / 32; w++) q[w*32 +: 32] = $urandom;
         q = q >> $urandom_range(0, QW - 1);
         if ($urandom_range(0, 1) == 1) q = -q;
         transact($sformatf("rand%0d", t), q, got, lat);
         check($sformatf("rand%0d_lat", t), 64'(lat), 64'(LAT));
         check($sformatf("rand%0d", t), 64'(got), 64'(model(q)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
